tile_seq_ctrl: RTL

- Sequencer that drives the 33-bit `inst` bus of the core for one tile.
- One tile = weight fetch, kernel load into the MAC array, activation streaming/execute, then OFIFO drain into psum SRAM.
- Sits between the testbench/host and the core; replaces hand-written instruction streams.
- One `start` pulse runs one complete tile and ends with a `done` pulse.

---
 rtl/tile_seq_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/tile_seq_ctrl.sv
// Tile sequencer: walks one tile through weight fetch, kernel load, activation
// streaming/execute and OFIFO drain by driving the core's 33-bit inst bus.
module tile_seq_ctrl #(
  parameter int col    = 8,
  parameter int row    = 8,
  parameter int k_gap  = 4,
  parameter int nact_w = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [10:0]       w_base,
  input  logic [10:0]       x_base,
  input  logic [10:0]       p_base,
  input  logic [nact_w-1:0] n_act,
  input  logic              l0_full,
  input  logic              ofifo_valid,
  output logic [32:0]       inst,
  output logic              busy,
  output logic              done
);

  localparam int CW_A = (nact_w > $clog2(col + 1)) ? nact_w : $clog2(col + 1);
  localparam int CW   = (CW_A > $clog2(k_gap + 1)) ? CW_A : $clog2(k_gap + 1);

  // Both memories disabled (CEN/WEN high), all addresses and strobes zero.
  localparam logic [32:0] INST_IDLE = {2'b11, 11'd0, 2'b11, 11'd0, 7'd0};

  if (row * 4 != 32) begin : g_row_chk
    $error("tile_seq_ctrl: row x 4b values must fill the 32-bit xmem word");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_W_RD, S_K_LD, S_K_WAIT, S_X_RD, S_X_EX, S_DRAIN, S_FIN
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [10:0]       wb_q, wb_d, xb_q, xb_d, pb_q, pb_d;
  logic [nact_w-1:0] nact_q, nact_d;
  logic [32:0]       inst_q, inst_d;
  logic              busy_q, busy_d, done_q, done_d;

  logic              rd_now, ofrd_now, rd_next, ofrd_next;
  logic [CW-1:0]     rd_total_d;
  logic [10:0]       rd_base_d;
  state_t            after_kld;

  // Each phase owns cnt_q: reads issued in W_RD/X_RD, cycles spent in K_LD/
  // K_WAIT/X_EX, OFIFO reads issued in DRAIN.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wb_d     = wb_q;
    xb_d     = xb_q;
    pb_d     = pb_q;
    nact_d   = nact_q;
    rd_now   = ~inst_q[19];
    ofrd_now = inst_q[2];

    if (k_gap == 0) after_kld = (nact_q == '0) ? S_FIN : S_X_RD;
    else            after_kld = S_K_WAIT;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_W_RD;
          cnt_d   = '0;
          wb_d    = w_base;
          xb_d    = x_base;
          pb_d    = p_base;
          nact_d  = n_act;
        end
      end
      S_W_RD: begin
        cnt_d = cnt_q + CW'(rd_now);
        if (cnt_d == CW'(col) && !rd_now) begin
          state_d = S_K_LD;
          cnt_d   = '0;
        end
      end
      S_K_LD: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(col - 1)) begin
          state_d = after_kld;
          cnt_d   = '0;
        end
      end
      S_K_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(k_gap - 1)) begin
          state_d = (nact_q == '0) ? S_FIN : S_X_RD;
          cnt_d   = '0;
        end
      end
      S_X_RD: begin
        cnt_d = cnt_q + CW'(rd_now);
        if (cnt_d == CW'(nact_q) && !rd_now) begin
          state_d = S_X_EX;
          cnt_d   = '0;
        end
      end
      S_X_EX: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(nact_q) - 1'b1) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end
      end
      S_DRAIN: begin
        cnt_d = cnt_q + CW'(ofrd_now);
        if (cnt_d == CW'(nact_q) && !ofrd_now) state_d = S_FIN;
      end
      S_FIN: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase

    // The bus is registered, so everything below describes the next cycle.
    rd_total_d = (state_d == S_W_RD) ? CW'(col) : CW'(nact_d);
    rd_base_d  = (state_d == S_W_RD) ? wb_d : xb_d;
    rd_next    = (state_d == S_W_RD || state_d == S_X_RD) &&
                 (cnt_d < rd_total_d) && !l0_full;
    ofrd_next  = (state_d == S_DRAIN) && (cnt_d < CW'(nact_d)) && ofifo_valid;

    inst_d    = INST_IDLE;
    inst_d[0] = (state_d == S_K_LD);
    inst_d[1] = (state_d == S_X_EX);
    inst_d[2] = ofrd_next;
    inst_d[3] = (state_d == S_K_LD) || (state_d == S_X_EX);
    inst_d[4] = rd_now;
    if (rd_next) begin
      inst_d[17:7] = rd_base_d + 11'(cnt_d);
      inst_d[19]   = 1'b0;
    end
    // An OFIFO row read this cycle is written to psum SRAM next cycle.
    if (ofrd_now) begin
      inst_d[30:20] = pb_q + 11'(cnt_q);
      inst_d[31]    = 1'b0;
      inst_d[32]    = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FIN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wb_q    <= '0;
      xb_q    <= '0;
      pb_q    <= '0;
      nact_q  <= '0;
      inst_q  <= INST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wb_q    <= wb_d;
      xb_q    <= xb_d;
      pb_q    <= pb_d;
      nact_q  <= nact_d;
      inst_q  <= inst_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign inst = inst_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
